// File: rtl/xbar_rr_switch.sv
// N-input, M-output crossbar with a per-output round-robin arbiter and one register stage
// per output; words addressed to a destination >= M are accepted and discarded.
module xbar_rr_switch #(
  parameter int N  = 4,
  parameter int M  = 4,
  parameter int W  = 32,
  parameter int DW = $clog2(M),
  parameter int SW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    in_valid,
  input  logic [N*DW-1:0] in_dest,
  input  logic [N*W-1:0]  in_data,
  output logic [N-1:0]    in_ready,
  output logic [M-1:0]    out_valid,
  input  logic [M-1:0]    out_ready,
  output logic [M*W-1:0]  out_data,
  output logic [M*SW-1:0] out_src,
  output logic [N-1:0]    grant,
  output logic            drop
);

  logic [M-1:0]  valid_q;
  logic [W-1:0]  data_q   [M];
  logic [SW-1:0] src_q    [M];
  logic [SW-1:0] rr_ptr_q [M];

  logic [DW-1:0] dest     [N];
  logic [N-1:0]  bad_dest;
  logic [N-1:0]  req      [M];
  logic [M-1:0]  out_free;
  logic [M-1:0]  win_found;
  logic [SW-1:0] win_idx  [M];
  logic [W-1:0]  win_data [M];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      dest[i]     = in_dest[i*DW +: DW];
      bad_dest[i] = (int'(dest[i]) >= M);
    end
  end

  // Winner is the lowest requester at or above rr_ptr, else the lowest requester overall.
  always_comb begin
    for (int j = 0; j < M; j++) begin
      logic          found_hi;
      logic          found_lo;
      logic [SW-1:0] idx_hi;
      logic [SW-1:0] idx_lo;
      found_hi    = 1'b0;
      found_lo    = 1'b0;
      idx_hi      = '0;
      idx_lo      = '0;
      out_free[j] = !valid_q[j] || out_ready[j];
      for (int i = N - 1; i >= 0; i--) begin
        req[j][i] = in_valid[i] && (dest[i] == DW'(j));
        if (req[j][i]) begin
          found_lo = 1'b1;
          idx_lo   = SW'(i);
          if (int'(rr_ptr_q[j]) <= i) begin
            found_hi = 1'b1;
            idx_hi   = SW'(i);
          end
        end
      end
      win_found[j] = found_hi || found_lo;
      win_idx[j]   = found_hi ? idx_hi : idx_lo;
    end
  end

  always_comb begin
    for (int j = 0; j < M; j++) begin
      win_data[j] = '0;
      for (int i = 0; i < N; i++) begin
        if (win_idx[j] == SW'(i)) begin
          win_data[j] = in_data[i*W +: W];
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      in_ready[i] = bad_dest[i];
      for (int j = 0; j < M; j++) begin
        if (dest[i] == DW'(j) && win_found[j] && win_idx[j] == SW'(i) && out_free[j]) begin
          in_ready[i] = 1'b1;
        end
      end
      if (rst) begin
        in_ready[i] = 1'b0;
      end
    end
    grant = in_valid & in_ready;
    drop  = |(in_valid & in_ready & bad_dest);
  end

  always_comb begin
    out_valid = valid_q;
    for (int j = 0; j < M; j++) begin
      out_data[j*W +: W]  = data_q[j];
      out_src[j*SW +: SW] = src_q[j];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int j = 0; j < M; j++) begin
        data_q[j]   <= '0;
        src_q[j]    <= '0;
        rr_ptr_q[j] <= '0;
      end
    end else begin
      for (int j = 0; j < M; j++) begin
        if (win_found[j] && out_free[j]) begin
          valid_q[j]  <= 1'b1;
          data_q[j]   <= win_data[j];
          src_q[j]    <= win_idx[j];
          rr_ptr_q[j] <= (int'(win_idx[j]) == N - 1) ? '0 : win_idx[j] + 1'b1;
        end else if (out_ready[j]) begin
          valid_q[j] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_xbar_rr_switch.sv
// Scoreboard bench for xbar_rr_switch: a 4x4 instance under directed and random traffic
// against a queue-based reference model, plus a 3x3 instance for drop and pointer wrap.
module tb_xbar_rr_switch;

  localparam int N  = 4;
  localparam int M  = 4;
  localparam int W  = 32;
  localparam int DW = 2;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    in_valid = '0;
  logic [N*DW-1:0] in_dest  = '0;
  logic [N*W-1:0]  in_data  = '0;
  logic [N-1:0]    in_ready;
  logic [M-1:0]    out_valid;
  logic [M-1:0]    out_ready = '1;
  logic [M*W-1:0]  out_data;
  logic [M*SW-1:0] out_src;
  logic [N-1:0]    grant;
  logic            drop;

  logic [2:0]  in_valid3 = '0;
  logic [5:0]  in_dest3  = '0;
  logic [95:0] in_data3  = '0;
  logic [2:0]  in_ready3;
  logic [2:0]  out_valid3;
  logic [2:0]  out_ready3 = '1;
  logic [95:0] out_data3;
  logic [5:0]  out_src3;
  logic [2:0]  grant3;
  logic        drop3;

  xbar_rr_switch #(.N(N), .M(M), .W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_dest(in_dest), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_src(out_src), .grant(grant), .drop(drop)
  );

  xbar_rr_switch #(.N(3), .M(3), .W(32)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid3), .in_dest(in_dest3), .in_data(in_data3),
    .in_ready(in_ready3), .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
    .out_src(out_src3), .grant(grant3), .drop(drop3)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;
  // Expected output words per destination: {data, 8-bit source index}.
  logic [W+7:0] sbq [M][$];
  int rr [M];
  logic [W+7:0] mon_e;
  logic [W-1:0] pat [N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input int i, input logic v, input int d, input logic [W-1:0] x);
    in_valid[i]          = v;
    in_dest[i*DW +: DW]  = DW'(d);
    in_data[i*W +: W]    = x;
  endtask

  // Reference: each free destination takes the first valid requester from its pointer onward.
  task automatic model_check();
    logic [N-1:0] er;
    int w;
    int i;
    bit free;
    er = '0;
    if (rst) begin
      chk("in_ready_in_reset", in_ready, 0);
      chk("grant_in_reset", grant, 0);
      chk("drop_in_reset", drop, 0);
      for (int j = 0; j < M; j++) begin
        sbq[j].delete();
        rr[j] = 0;
      end
      return;
    end
    for (int j = 0; j < M; j++) begin
      free = (sbq[j].size() == 0) || out_ready[j];
      w = -1;
      for (int k = 0; k < N; k++) begin
        i = (rr[j] + k) % N;
        if (w < 0 && in_valid[i] && int'(in_dest[i*DW +: DW]) == j) w = i;
      end
      if (w >= 0 && free) begin
        er[w] = 1'b1;
        sbq[j].push_back({in_data[w*W +: W], 8'(w)});
        rr[j] = (w + 1) % N;
      end
    end
    chk("in_ready", in_ready, er);
    chk("grant", grant, er & in_valid);
    chk("drop", drop, 0);
  endtask

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      for (int j = 0; j < M; j++) begin
        chk($sformatf("out_valid[%0d]", j), out_valid[j], sbq[j].size() != 0);
        if (out_valid[j] && out_ready[j] && sbq[j].size() != 0) begin
          mon_e = sbq[j].pop_front();
          chk($sformatf("out_data[%0d]", j), out_data[j*W +: W], mon_e[W+7:8]);
          chk($sformatf("out_src[%0d]", j), out_src[j*SW +: SW], mon_e[SW-1:0]);
        end
      end
    end
  end

  task automatic eval();
    @(negedge clk);
    #1;
    model_check();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    pat[0] = 32'hA1A1A1A1;
    pat[1] = 32'hB2B2B2B2;
    pat[2] = 32'hC3C3C3C3;
    pat[3] = 32'hD4D4D4D4;
    eval();
    adv();
    rst = 1'b0;
    mon_en = 1'b1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_out_src", out_src, 0);

    // One input per destination: all four transfer together.
    for (int i = 0; i < N; i++) set_in(i, 1'b1, i, pat[i]);
    eval();
    chk("parallel_grant", grant, 4'b1111);
    adv();
    in_valid  = '0;
    out_ready = '0;
    eval();
    chk("parallel_out_valid", out_valid, 4'b1111);
    for (int j = 0; j < M; j++) begin
      chk("parallel_lane_data", out_data[j*W +: W], pat[j]);
      chk("parallel_lane_src", out_src[j*SW +: SW], j);
    end
    adv();

    // Reset while every output is full and every input is requesting.
    rst = 1'b1;
    for (int i = 0; i < N; i++) set_in(i, 1'b1, i, pat[i]);
    eval();
    adv();
    rst = 1'b0;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_out_src", out_src, 0);
    out_ready = '1;

    // Four-way contention on destination 2.
    for (int c = 0; c < 5; c++) begin
      for (int i = 0; i < N; i++) set_in(i, 1'b1, 2, $urandom);
      eval();
      chk($sformatf("rr_grant_c%0d", c), grant, 4'b0001 << (c % 4));
      adv();
    end
    in_valid = '0;
    eval();
    adv();

    // Move rr_ptr[0] to 2, then inputs 1 and 3 contend.
    set_in(1, 1'b1, 0, 32'h11110000);
    eval();
    adv();
    set_in(1, 1'b1, 0, 32'h11111111);
    set_in(3, 1'b1, 0, 32'h33333333);
    eval();
    chk("ptr2_first_grant", grant, 4'b1000);
    adv();
    eval();
    chk("ptr2_second_grant", grant, 4'b0010);
    adv();
    in_valid = '0;
    eval();
    adv();

    // Back-pressure on output 1, then simultaneous pop and accept.
    out_ready[1] = 1'b0;
    set_in(0, 1'b1, 1, 32'hDEADBEEF);
    eval();
    chk("bp_first_grant", grant, 4'b0001);
    adv();
    for (int c = 0; c < 2; c++) begin
      eval();
      chk("bp_stall_ready", in_ready[0], 0);
      chk("bp_hold_data", out_data[1*W +: W], 32'hDEADBEEF);
      adv();
    end
    out_ready[1] = 1'b1;
    set_in(0, 1'b1, 1, 32'hCAFEBABE);
    eval();
    chk("bp_popaccept_grant", grant, 4'b0001);
    adv();
    in_valid = '0;
    eval();
    chk("bp_valid_kept", out_valid[1], 1);
    chk("bp_new_data", out_data[1*W +: W], 32'hCAFEBABE);
    adv();

    repeat (400) begin
      for (int i = 0; i < N; i++)
        set_in(i, $urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom);
      for (int j = 0; j < M; j++) out_ready[j] = ($urandom_range(0, 3) != 0);
      eval();
      adv();
    end
    in_valid  = '0;
    out_ready = '1;
    repeat (2) begin
      eval();
      adv();
    end

    // 3x3 instance: out-of-range destination, then pointer wrap at N=3.
    rst = 1'b1;
    eval();
    adv();
    rst = 1'b0;
    in_valid3        = 3'b001;
    in_dest3[1:0]    = 2'd3;
    in_data3[31:0]   = 32'h12345678;
    @(negedge clk);
    #1;
    chk("drop_ready", in_ready3[0], 1);
    chk("drop_pulse", drop3, 1);
    chk("drop_grant", grant3, 3'b001);
    adv();
    in_valid3 = '0;
    @(negedge clk);
    #1;
    chk("drop_pulse_end", drop3, 0);
    chk("drop_no_output", out_valid3, 0);
    adv();
    in_valid3 = 3'b111;
    in_dest3  = {2'd1, 2'd1, 2'd1};
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("wrap3_grant_c%0d", c), grant3, 3'b001 << (c % 3));
      if (c > 0) chk($sformatf("wrap3_src_c%0d", c), out_src3[3:2], (c - 1) % 3);
      adv();
    end
    in_valid3 = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
